// File: rtl/clk_div_n.sv
// clk_div_n: runtime-programmable modulo-N clock-enable divider with a ~50 % square output.
// Latency: all outputs are registered. The first tick after reset lands on the Nth enabled edge.
//          A new divisor takes effect at the next wrap, or at once on sync_clr.
// Backpressure: none. en gates counting, and loads are shadowed until a period boundary.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   en            count enable
//   sync_clr      synchronous phase restart; has priority over en
//   div_load      load request for div_in
//   div_in        new divisor (0 is rejected and flagged on err)
//   tick          one-cycle strobe at each period wrap
//   sq            square wave, high for ceil(N/2) of every N counts
//   count         current phase, 0..N-1
//   div_cur       divisor currently in force
//   err           one-cycle strobe after a rejected (zero) load
module clk_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             sq,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_cur,
    output logic             err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             eff_vld;
    logic [WIDTH-1:0] eff_div;
    logic             wrap;
    logic [WIDTH:0]   half_n;

    // A valid load on this clock is treated as already pending, so a load on
    // the wrap or clear clock is applied at that boundary.
    assign load_ok = div_load && (div_in != '0);
    assign eff_vld = pend_vld_q || load_ok;
    assign eff_div = load_ok ? div_in : pend_div_q;
    assign wrap    = (count_q == div_q - 1'b1);

    always_comb begin
        count_d    = count_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        err_d      = div_load && (div_in == '0);
        half_n     = '0;

        if (load_ok) begin
            pend_div_d = div_in;
            pend_vld_d = 1'b1;
        end

        if (sync_clr) begin
            count_d = '0;
            if (eff_vld) begin
                div_d      = eff_div;
                pend_vld_d = 1'b0;
            end
            // Count 0 is always in the high half, because N is at least 1.
            sq_d = 1'b1;
        end else if (en) begin
            if (wrap) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (eff_vld) begin
                    div_d      = eff_div;
                    pend_vld_d = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
            // ceil(N/2) needs one extra bit so that N = 2^WIDTH-1 does not overflow.
            half_n = ({1'b0, div_d} + 1'b1) >> 1;
            sq_d   = ({1'b0, count_d} < half_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            div_q      <= WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
            err_q      <= err_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign count   = count_q;
    assign div_cur = div_q;
    assign err     = err_q;

endmodule

// File: tb/tb_clk_div_n.sv
module tb_clk_div_n;
    localparam int W   = 8;
    localparam int DEF = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sync_clr;
    logic         div_load;
    logic [W-1:0] div_in;
    logic         tick;
    logic         sq;
    logic [W-1:0] count;
    logic [W-1:0] div_cur;
    logic         err;

    clk_div_n #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .div_load (div_load),
        .div_in   (div_in),
        .tick     (tick),
        .sq       (sq),
        .count    (count),
        .div_cur  (div_cur),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase counter, active divisor, optional pending divisor.
    int m_cnt, m_n, m_pend;
    bit m_pv, m_tick, m_sq, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_n = DEF; m_pend = 0; m_pv = 0;
        m_tick = 0; m_sq = 0; m_err = 0;
    endtask

    task automatic model_step(input bit e, input bit sc, input bit ld, input int din);
        m_err = ld && (din == 0);
        if (ld && din != 0) begin
            m_pend = din;
            m_pv   = 1;
        end
        if (sc) begin
            m_cnt  = 0;
            m_tick = 0;
            if (m_pv) begin m_n = m_pend; m_pv = 0; end
            m_sq = 1;
        end else if (e) begin
            if (m_cnt == m_n - 1) begin
                m_cnt  = 0;
                m_tick = 1;
                if (m_pv) begin m_n = m_pend; m_pv = 0; end
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 0;
            end
            m_sq = (m_cnt < (m_n + 1) / 2);
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tick"},  32'(tick),    32'(m_tick));
        chk({tag, ".sq"},    32'(sq),      32'(m_sq));
        chk({tag, ".count"}, 32'(count),   m_cnt);
        chk({tag, ".div"},   32'(div_cur), m_n);
        chk({tag, ".err"},   32'(err),     32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, update the model, compare 1 ns later.
    task automatic cyc(input bit e, input bit sc, input bit ld, input int din, input string tag);
        en = e; sync_clr = sc; div_load = ld; div_in = din[W-1:0];
        @(posedge clk);
        model_step(e, sc, ld, din);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        en = 0; sync_clr = 0; div_load = 0; div_in = '0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        int gap;
        bit seen;
        reset = 1'b1; en = 0; sync_clr = 0; div_load = 0; div_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst.div_const", 32'(div_cur), DEF);
        reset = 1'b0;

        // Default divide-by-3 cadence.
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, 0, 0, "tp1");
            chk("tp1.tick_const",  32'(tick),  32'(i % 3 == 0));
            chk("tp1.count_const", 32'(count), i % 3);
            chk("tp1.sq_const",    32'(sq),    32'(i % 3 != 2));
        end

        // Load 5 mid-period: the period finishes at 3 and the next one is 5 long.
        cyc(1, 0, 0, 0, "tp2a");
        cyc(1, 0, 1, 5, "tp2b");
        chk("tp2.div_hold", 32'(div_cur), 3);
        cyc(1, 0, 0, 0, "tp2c");
        chk("tp2.wrap_tick", 32'(tick), 1);
        chk("tp2.div_new",   32'(div_cur), 5);
        gap = 0; seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc(1, 0, 0, 0, "tp2d");
            gap++;
            if (tick) seen = 1;
        end
        chk("tp2.gap", gap, 5);

        // Zero load is rejected.
        cyc(1, 0, 1, 0, "tp3a");
        chk("tp3.err",  32'(err), 1);
        chk("tp3.div",  32'(div_cur), 5);
        cyc(1, 0, 0, 0, "tp3b");
        chk("tp3.err_off", 32'(err), 0);

        // Load 1 then sync_clr: immediate N=1, tick and sq continuously high.
        cyc(1, 0, 1, 1, "tp4a");
        cyc(1, 1, 0, 0, "tp4b");
        chk("tp4.div", 32'(div_cur), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, "tp4c");
            chk("tp4.tick", 32'(tick), 1);
            chk("tp4.sq",   32'(sq), 1);
        end

        // N=4 with en gaps: count holds, tick only after 4 enabled edges.
        cyc(1, 1, 1, 4, "tp5a");
        cyc(1, 0, 0, 0, "tp5b");
        cyc(0, 0, 0, 0, "tp5c");
        chk("tp5.hold_cnt", 32'(count), 1);
        chk("tp5.no_tick",  32'(tick), 0);
        cyc(0, 0, 0, 0, "tp5d");
        cyc(1, 0, 0, 0, "tp5e");
        cyc(1, 0, 0, 0, "tp5f");
        cyc(1, 0, 0, 0, "tp5g");
        chk("tp5.tick", 32'(tick), 1);

        // Reset mid-period with a load pending.
        cyc(1, 1, 1, 3, "tp6a");
        cyc(1, 0, 0, 0, "tp6b");
        cyc(1, 0, 0, 0, "tp6c");
        cyc(0, 0, 1, 7, "tp6d");
        chk("tp6.cnt2", 32'(count), 2);
        pulse_reset("tp6rst");
        chk("tp6.div_rst", 32'(div_cur), 3);
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 0, "tp6e");
        chk("tp6.tick", 32'(tick), 1);
        chk("tp6.no_pend", 32'(div_cur), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit e, sc, ld;
            int din;
            if ($urandom_range(0, 499) == 0) pulse_reset("rnd_rst");
            e   = ($urandom_range(0, 3) != 0);
            sc  = ($urandom_range(0, 29) == 0);
            ld  = ($urandom_range(0, 11) == 0);
            din = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 9));
            cyc(e, sc, ld, din, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_n.md
# clk_div_n

Parametrised, runtime-programmable clock-enable divider: a free-running modulo-N counter that emits a one-cycle `tick` every N enabled clocks and an optional ~50 % square output. It is the general successor of the fixed divide-by-3 state machine. It generates strobes for timers, UART baud enables and LED blinkers within the same clock domain. Divisor changes are shadowed and take effect only at a period boundary, so the output never produces a runt period.

## Interface
- `WIDTH`, 8: width of divisor and counter; legal divisors 1..2^WIDTH-1.
- `DEFAULT_DIV`, 3: divisor active after reset; must be 1..2^WIDTH-1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; the counter advances only on clocks where `en`=1.
- `sync_clr`  in  1  synchronous phase restart.
- `div_load`  in  1  load request for `div_in`.
- `div_in`  in  WIDTH  new divisor.
- `tick`  out  1  registered one-cycle strobe at each period wrap.
- `sq`  out  1  registered square wave, high for ceil(N/2) of every N enabled counts.
- `count`  out  WIDTH  current phase, 0..N-1.
- `div_cur`  out  WIDTH  divisor currently in force.
- `err`  out  1  one-cycle strobe: rejected load (`div_in`=0).

## Operation
- State: `count`, `div_cur` (active N), `pend_div` plus `pend_vld` (shadow), and registered `tick`, `sq`, `err`.
- Reset values: `count`=0, `tick`=0, `sq`=0, `err`=0, `div_cur`=DEFAULT_DIV, `pend_vld`=0.
- Load:
  - `div_load`=1 with `div_in`≠0 stores `pend_div`=`div_in` and sets `pend_vld`=1.
  - If several loads arrive before a wrap, the last one wins.
  - `div_load`=1 with `div_in`=0 pulses `err` the next cycle. It leaves the shadow and `div_cur` unchanged.
- Wrap: an enabled clock where `count`==`div_cur`-1.
  - `count`←0 and `tick`←1.
  - If a shadow value is pending, `div_cur`←pending value and `pend_vld`←0. A load presented on the wrap clock itself counts as pending and is applied at that wrap.
- Enabled non-wrap clock: `count`←`count`+1, `tick`←0.
- `en`=0: `count`, `div_cur` and `sq` hold; `tick`←0. Loads are still captured into the shadow.
- `sync_clr`=1: has priority over `en`.
  - `count`←0, `tick`←0.
  - Any pending or same-cycle valid load is applied to `div_cur` immediately.
  - `sq` takes the value computed for count 0, i.e. 1.
- `sq` is registered from the post-update count: `sq`←(next_count < (N_next+1)/2), using integer division. N_next is the divisor in force after the edge.
- N=1: every enabled clock is a wrap. `tick` stays high while `en`=1, `count` stays 0 and `sq` stays 1.
- Counter arithmetic is WIDTH bits. `count` never exceeds `div_cur`-1, because the divisor changes only at a wrap or a clear.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- First `tick` after reset (`en` held high, N=DEFAULT_DIV) occurs on the Nth rising edge. `tick` is then high for exactly one cycle every N enabled cycles.
- Load latency: a new divisor governs the period that starts at the next wrap. Worst case is N_old cycles; `sync_clr` makes it immediate.
- `err` is asserted on the edge after the bad load, for one cycle.
- Reset asserted mid-period: all state returns to reset values asynchronously. A pending load is discarded.
- `en` dropping on a wrap clock: `tick` still asserts for that edge, because the wrap itself was enabled.

## Test plan
- Reset, `en`=1 with DEFAULT_DIV=3 -> `tick` high on edges 3, 6, 9; `count` sequence 1,2,0,1,2,0; `sq` sequence 1,0,1,1,0,1.
- Load 5 while `count`=1 (N=3) -> period finishes at 3; next `tick`s are 5 cycles apart; `div_cur` changes to 5 on the wrap edge.
- Load 0 -> `err` high for one cycle; `div_cur` unchanged; `tick` cadence undisturbed.
- Load 1 then `sync_clr` -> `div_cur`=1 immediately; `tick` and `sq` continuously 1 while `en`=1.
- `en` toggled 1,0,0,1 with N=4 -> `count` holds during the low cycles; `tick` appears after 4 enabled edges, with no tick while disabled.
- Assert `reset` with `count`=2 and a load pending -> `count`=0, `tick`=`sq`=`err`=0, `div_cur`=3, pending load discarded.
